// File: rtl/id_stage.sv
// Decode stage: instruction select, register read with write-back bypass, ID/EX pipeline registers.
// Optional macro ID_LOAD_USE_STALL_EN enables load-use stall detection and the stalled-word hold register.
module id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [1:0]  INST_BIOS = 2'd0,
  parameter logic [1:0]  INST_IMEM = 2'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  input  logic [1:0]  id_inst_sel,
  input  logic [31:0] bios_dout,
  input  logic [31:0] imem_dout,
  input  logic        wb_flush,
  input  logic        ex_target_taken,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_inst,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic        ex_reg_we,
  output logic        ex_mem_read,
  output logic        ex_mem_write
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  logic [31:0] w_sel_inst;
  logic [31:0] w_inst;
  opcode_e     w_opcode;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm;
  logic        w_we_raw, w_reg_we, w_mem_read, w_mem_write;
  logic [31:0] w_rs1_data, w_rs2_data;
  logic        w_flush;

  always_comb begin
    w_sel_inst = NOP;
    if (id_inst_sel == INST_BIOS)      w_sel_inst = bios_dout;
    else if (id_inst_sel == INST_IMEM) w_sel_inst = imem_dout;
  end

  assign w_flush = wb_flush | ex_target_taken;

`ifdef ID_LOAD_USE_STALL_EN
  logic        r_holding;
  logic [31:0] r_hold_inst;
  logic        w_uses_rs1, w_uses_rs2;

  assign w_inst = r_holding ? r_hold_inst : w_sel_inst;

  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_REG, OP_STORE, OP_BRANCH: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: w_uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign id_stall = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((w_uses_rs1 && (w_rs1 == ex_rd)) || (w_uses_rs2 && (w_rs2 == ex_rd))) &&
                    !w_flush;

  // Memory data moves on during the stall, so the stalled word is captured once and replayed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_holding   <= 1'b0;
      r_hold_inst <= NOP;
    end else if (w_flush || !id_stall) begin
      r_holding   <= 1'b0;
    end else if (!r_holding) begin
      r_holding   <= 1'b1;
      r_hold_inst <= w_sel_inst;
    end
  end
`else
  assign w_inst   = w_sel_inst;
  assign id_stall = 1'b0;
`endif

  assign w_opcode = opcode_e'(w_inst[6:0]);
  assign w_rs1    = w_inst[19:15];
  assign w_rs2    = w_inst[24:20];
  assign w_rd     = w_inst[11:7];
  assign rf_ra1   = w_rs1;
  assign rf_ra2   = w_rs2;

  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'b0};
  assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  always_comb begin
    w_imm       = '0;
    w_we_raw    = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    case (w_opcode)
      OP_REG:   w_we_raw = 1'b1;
      OP_IMM, OP_JALR: begin
        w_we_raw = 1'b1;
        w_imm    = w_imm_i;
      end
      OP_LOAD: begin
        w_we_raw   = 1'b1;
        w_mem_read = 1'b1;
        w_imm      = w_imm_i;
      end
      OP_STORE: begin
        w_mem_write = 1'b1;
        w_imm       = w_imm_s;
      end
      OP_BRANCH: w_imm = w_imm_b;
      OP_LUI, OP_AUIPC: begin
        w_we_raw = 1'b1;
        w_imm    = w_imm_u;
      end
      OP_JAL: begin
        w_we_raw = 1'b1;
        w_imm    = w_imm_j;
      end
      default: ;
    endcase
  end

  assign w_reg_we = w_we_raw && (w_rd != 5'd0);

  // A register written back this cycle is visible to the instruction reading it now.
  always_comb begin
    w_rs1_data = rf_rd1;
    if (w_rs1 == 5'd0)                     w_rs1_data = '0;
    else if (wb_we && (wb_rd == w_rs1))    w_rs1_data = wb_data;
    w_rs2_data = rf_rd2;
    if (w_rs2 == 5'd0)                     w_rs2_data = '0;
    else if (wb_we && (wb_rd == w_rs2))    w_rs2_data = wb_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= RESET_PC;
      ex_inst      <= NOP;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_reg_we    <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (w_flush || id_stall) begin
      ex_valid     <= 1'b0;
      ex_pc        <= RESET_PC;
      ex_inst      <= NOP;
      ex_rd        <= '0;
      ex_reg_we    <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_inst      <= w_inst;
      ex_rs1       <= w_rs1;
      ex_rs2       <= w_rs2;
      ex_rd        <= w_rd;
      ex_rs1_data  <= w_rs1_data;
      ex_rs2_data  <= w_rs2_data;
      ex_imm       <= w_imm;
      ex_reg_we    <= w_reg_we;
      ex_mem_read  <= w_mem_read;
      ex_mem_write <= w_mem_write;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: vector table through a scoreboard queue, plus stall/flush/reset sequences.
module tb_id_stage;

  localparam logic [1:0]  SEL_BIOS = 2'd0;
  localparam logic [1:0]  SEL_IMEM = 2'd1;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC   = 32'h4000_0000;
  localparam logic [31:0] LW_X2    = 32'h0000_A103;
  localparam logic [31:0] ADD_X3   = 32'h0021_01B3;
  localparam logic [31:0] ADDI_X4  = 32'hFFF2_0213;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] id_pc = '0;
  logic [1:0]  id_inst_sel = SEL_BIOS;
  logic [31:0] bios_dout = NOP, imem_dout = NOP;
  logic        wb_flush = 1'b0, ex_target_taken = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1 = '0, rf_rd2 = '0;
  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_inst;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic        ex_reg_we, ex_mem_read, ex_mem_write;

  id_stage #(.RESET_PC(RST_PC), .INST_BIOS(SEL_BIOS), .INST_IMEM(SEL_IMEM)) dut (
    .clk(clk), .rst(rst), .id_pc(id_pc), .id_inst_sel(id_inst_sel),
    .bios_dout(bios_dout), .imem_dout(imem_dout),
    .wb_flush(wb_flush), .ex_target_taken(ex_target_taken),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] bios, imem, rf1, rf2;
    logic        wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic        fl, tk;
    logic [31:0] e_imm;
    logic        e_we, e_mr, e_mw;
    logic [31:0] e_d1, e_d2;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, inst;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, d1, d2;
    logic        we, mr, mw;
  } exp_t;

  exp_t sb[$];
  vec_t vt[18];

  function automatic vec_t mkv(input logic [1:0] sel, input logic [31:0] bios, imem, rf1, rf2,
                               input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd,
                               input logic fl, tk, input logic [31:0] imm,
                               input logic we, mr, mw, input logic [31:0] d1, d2);
    vec_t v;
    v.sel = sel; v.bios = bios; v.imem = imem; v.rf1 = rf1; v.rf2 = rf2;
    v.wbe = wbe; v.wbr = wbr; v.wbd = wbd; v.fl = fl; v.tk = tk;
    v.e_imm = imm; v.e_we = we; v.e_mr = mr; v.e_mw = mw; v.e_d1 = d1; v.e_d2 = d2;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] w);
    id_inst_sel = SEL_IMEM; imem_dout = w; bios_dout = 32'hFFFF_FFFF;
    wb_flush = 1'b0; ex_target_taken = 1'b0; wb_we = 1'b0;
    rf_rd1 = '0; rf_rd2 = '0;
  endtask

  task automatic chk_ex_state(input string tag, input logic v, input logic [31:0] inst);
    chk({tag, "_valid"}, 32'(ex_valid), 32'(v));
    chk({tag, "_inst"}, ex_inst, inst);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e, g;
    logic [31:0] inst, pc;
    logic        bub;

    vt[0]  = mkv(SEL_BIOS, 32'h0050_0093, 32'hFFFF_FFFF, 32'h1234, 32'h5678, 0, 0, 0, 0, 0, 32'd5, 1, 0, 0, 32'h0, 32'h5678);
    vt[1]  = mkv(SEL_IMEM, 32'hFFFF_FFFF, 32'h0072_8333, 32'h0, 32'h77, 1, 5, 32'hDEAD_BEEF, 0, 0, 32'h0, 1, 0, 0, 32'hDEAD_BEEF, 32'h77);
    vt[2]  = mkv(SEL_IMEM, 32'hFFFF_FFFF, 32'h0070_0333, 32'h999, 32'h77, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h77);
    vt[3]  = mkv(SEL_IMEM, 32'hFFFF_FFFF, 32'h0053_8333, 32'hAAAA, 32'h1, 1, 5, 32'hCAFE_F00D, 0, 0, 32'h0, 1, 0, 0, 32'hAAAA, 32'hCAFE_F00D);
    vt[4]  = mkv(SEL_IMEM, 32'hFFFF_FFFF, 32'h0053_8333, 32'hAAAA, 32'h1, 0, 5, 32'hCAFE_F00D, 0, 0, 32'h0, 1, 0, 0, 32'hAAAA, 32'h1);
    vt[5]  = mkv(2'b11, 32'h0050_0093, 32'h0072_8333, 32'h1, 32'h2, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    vt[6]  = mkv(2'b10, 32'h0050_0093, 32'h0072_8333, 32'h1, 32'h2, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    vt[7]  = mkv(SEL_BIOS, 32'hFE20_8EE3, 32'hFFFF_FFFF, 32'h11, 32'h22, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'h11, 32'h22);
    vt[8]  = mkv(SEL_BIOS, 32'h0010_00EF, 32'hFFFF_FFFF, 32'h11, 32'h22, 0, 0, 0, 0, 0, 32'h0000_0800, 1, 0, 0, 32'h0, 32'h22);
    vt[9]  = mkv(SEL_BIOS, LW_X2, 32'hFFFF_FFFF, 32'h40, 32'h33, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0, 32'h40, 32'h0);
    vt[10] = mkv(SEL_BIOS, 32'hFE30_AC23, 32'hFFFF_FFFF, 32'h40, 32'h3, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 0, 0, 1, 32'h40, 32'h3);
    vt[11] = mkv(SEL_BIOS, 32'hABCD_E2B7, 32'hFFFF_FFFF, 32'h5, 32'h6, 0, 0, 0, 0, 0, 32'hABCD_E000, 1, 0, 0, 32'h5, 32'h6);
    vt[12] = mkv(SEL_BIOS, 32'h0000_1017, 32'hFFFF_FFFF, 32'h5, 32'h6, 0, 0, 0, 0, 0, 32'h0000_1000, 0, 0, 0, 32'h0, 32'h0);
    vt[13] = mkv(SEL_BIOS, 32'h7FF1_00E7, 32'hFFFF_FFFF, 32'h100, 32'h200, 0, 0, 0, 0, 0, 32'h0000_07FF, 1, 0, 0, 32'h100, 32'h200);
    vt[14] = mkv(SEL_BIOS, ADDI_X4, 32'hFFFF_FFFF, 32'h7, 32'h8, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    vt[15] = mkv(SEL_BIOS, ADDI_X4, 32'hFFFF_FFFF, 32'h7, 32'h8, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 32'h7, 32'h8);
    vt[16] = mkv(SEL_BIOS, 32'h0050_0093, 32'hFFFF_FFFF, 32'h1234, 32'h5678, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    vt[17] = mkv(SEL_BIOS, 32'h0050_0093, 32'hFFFF_FFFF, 32'h1234, 32'h5678, 0, 0, 0, 0, 0, 32'd5, 1, 0, 0, 32'h0, 32'h5678);

    // Reset state
    #2;
    chk("rst_async_valid", 32'(ex_valid), 32'h0);
    tick(); tick();
    chk("rst_valid", 32'(ex_valid), 32'h0);
    chk("rst_pc", ex_pc, RST_PC);
    chk("rst_inst", ex_inst, NOP);
    chk("rst_rd", 32'(ex_rd), 32'h0);
    chk("rst_imm", ex_imm, 32'h0);
    chk("rst_d1", ex_rs1_data, 32'h0);
    chk("rst_d2", ex_rs2_data, 32'h0);
    chk("rst_ctl", {29'h0, ex_reg_we, ex_mem_read, ex_mem_write}, 32'h0);
    chk("rst_stall", 32'(id_stall), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Vector table through the scoreboard
    for (int i = 0; i < 18; i++) begin
      pc = RST_PC + 32'(4 * i);
      id_pc = pc; id_inst_sel = vt[i].sel; bios_dout = vt[i].bios; imem_dout = vt[i].imem;
      rf_rd1 = vt[i].rf1; rf_rd2 = vt[i].rf2;
      wb_we = vt[i].wbe; wb_rd = vt[i].wbr; wb_data = vt[i].wbd;
      wb_flush = vt[i].fl; ex_target_taken = vt[i].tk;
      inst = (vt[i].sel == SEL_BIOS) ? vt[i].bios : (vt[i].sel == SEL_IMEM) ? vt[i].imem : NOP;
      bub = vt[i].fl | vt[i].tk;
      e.valid = !bub; e.pc = pc; e.inst = bub ? NOP : inst;
      e.rd = bub ? 5'd0 : inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
      e.imm = vt[i].e_imm; e.d1 = vt[i].e_d1; e.d2 = vt[i].e_d2;
      e.we = bub ? 1'b0 : vt[i].e_we; e.mr = bub ? 1'b0 : vt[i].e_mr; e.mw = bub ? 1'b0 : vt[i].e_mw;
      sb.push_back(e);
      #1;
      chk($sformatf("v%0d_ra1", i), 32'(rf_ra1), 32'(inst[19:15]));
      chk($sformatf("v%0d_ra2", i), 32'(rf_ra2), 32'(inst[24:20]));
      chk($sformatf("v%0d_stall", i), 32'(id_stall), 32'h0);
      tick();
      if (sb.size() == 0) begin
        chk($sformatf("v%0d_sb_empty", i), 32'h1, 32'h0);
      end else begin
        g = sb.pop_front();
        chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(g.valid));
        chk($sformatf("v%0d_inst", i), ex_inst, g.inst);
        chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(g.rd));
        chk($sformatf("v%0d_ctl", i), {29'h0, ex_reg_we, ex_mem_read, ex_mem_write}, {29'h0, g.we, g.mr, g.mw});
        if (g.valid) begin
          chk($sformatf("v%0d_pc", i), ex_pc, g.pc);
          chk($sformatf("v%0d_rs1", i), 32'(ex_rs1), 32'(g.rs1));
          chk($sformatf("v%0d_rs2", i), 32'(ex_rs2), 32'(g.rs2));
          chk($sformatf("v%0d_imm", i), ex_imm, g.imm);
          chk($sformatf("v%0d_d1", i), ex_rs1_data, g.d1);
          chk($sformatf("v%0d_d2", i), ex_rs2_data, g.d2);
        end
      end
    end

    // Load-use: lw x2 then add x3,x2,x2
    drive_word(LW_X2);
    tick();
    chk("lu_load_mr", 32'(ex_mem_read), 32'h1);
    chk("lu_load_rd", 32'(ex_rd), 32'h2);
    drive_word(ADD_X3);
    #1;
`ifdef ID_LOAD_USE_STALL_EN
    chk("lu_stall", 32'(id_stall), 32'h1);
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'h0);
    imem_dout = ADDI_X4;
    #1;
    chk("lu_stall_drop", 32'(id_stall), 32'h0);
    tick();
`else
    chk("lu_nostall", 32'(id_stall), 32'h0);
    tick();
`endif
    chk_ex_state("lu_issue", 1'b1, ADD_X3);
    chk("lu_rs1", 32'(ex_rs1), 32'h2);
    chk("lu_rs2", 32'(ex_rs2), 32'h2);
    chk("lu_rd", 32'(ex_rd), 32'h3);

    // Load-use coinciding with a taken branch: flush wins
    drive_word(LW_X2);
    tick();
    drive_word(ADD_X3);
    ex_target_taken = 1'b1;
    #1;
    chk("fs_stall", 32'(id_stall), 32'h0);
    tick();
    chk_ex_state("fs_bubble", 1'b0, NOP);
    drive_word(ADDI_X4);
    #1;
    chk("fs_stall_after", 32'(id_stall), 32'h0);
    tick();
    chk_ex_state("fs_next", 1'b1, ADDI_X4);

`ifdef ID_LOAD_USE_STALL_EN
    // Reset during the stall cycle clears the request at once
    drive_word(LW_X2);
    tick();
    drive_word(ADD_X3);
    #1;
    chk("rs_stall_pre", 32'(id_stall), 32'h1);
    rst = 1'b0;
    #1;
    chk("rs_stall_clr", 32'(id_stall), 32'h0);
    chk("rs_valid_clr", 32'(ex_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    // Reset after the hold word was captured: the stale word must not reissue
    drive_word(LW_X2);
    tick();
    drive_word(ADD_X3);
    tick();
    imem_dout = ADDI_X4;
    #1;
    rst = 1'b0;
    #1;
    chk("rh_valid_clr", 32'(ex_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_ex_state("rh_next", 1'b1, ADDI_X4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the RISC-V core pipeline, directly downstream of the fetch stage. It consumes the fetched PC and instruction-source select and picks the instruction word from BIOS or IMEM read data. It decodes register indices, immediate and control bits, reads the register file with write-back bypass, and detects load-use hazards, driving `id_stall` back to fetch. It registers everything into the ID/EX pipeline registers, inserting bubbles on stall and flush.

## Interface
- `RESET_PC`, 32'h4000_0000: value driven on `ex_pc` while the EX slot is reset/bubbled.
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `id_pc` input 32: PC of the instruction in ID.
- `id_inst_sel` input 2: `INST_BIOS` selects `bios_dout`, `INST_IMEM` selects `imem_dout`; any other code is a NOP (32'h0000_0013).
- `bios_dout`, `imem_dout` input 32 each: synchronous-read instruction memory data.
- `wb_flush`, `ex_target_taken` input 1 each: kill the instruction currently in ID.
- `wb_we` input 1, `wb_rd` input 5, `wb_data` input 32: register write-back port.
- `rf_ra1`, `rf_ra2` output 5 each: register file read addresses (combinational from ID instruction).
- `rf_rd1`, `rf_rd2` input 32 each: register file read data.
- `id_stall` output 1: load-use stall request to fetch.
- `ex_valid` output 1; `ex_pc` output 32; `ex_inst` output 32; `ex_rs1`, `ex_rs2`, `ex_rd` output 5 each; `ex_rs1_data`, `ex_rs2_data`, `ex_imm` output 32 each; `ex_reg_we`, `ex_mem_read`, `ex_mem_write` output 1 each: ID/EX registers.

## Operation
- Instruction select: a mux on `id_inst_sel`, except while holding (below).
- Hold register: on the first stalled cycle, the selected word is captured into `hold_inst` and `holding` is set. While `holding`=1, `hold_inst` replaces memory data. `holding` clears on any cycle with `id_stall`=0 or on a flush.
- Decode: the opcode drives `uses_rs1`/`uses_rs2`.
  - R, I, S, B, load, JALR use rs1.
  - R, S, B use rs2.
  - LUI, AUIPC, JAL use neither.
- Immediates: I/S/B/U/J formats, sign-extended to 32 bits, with B/J bit 0 = 0. R-type gives 0.
- Control bits: `reg_we` = R, I, load, LUI, AUIPC, JAL, JALR, forced 0 when rd=0. `mem_read` = load. `mem_write` = store.
- Read bypass: if `wb_we` && `wb_rd`!=0 && `wb_rd`==rs*, the data is `wb_data`, else `rf_rd*`. x0 always reads 0.
- Load-use hazard: `id_stall` = `ex_valid` && `ex_mem_read` && `ex_rd`!=0 && ((`uses_rs1` && rs1==`ex_rd`) || (`uses_rs2` && rs2==`ex_rd`)) && !flush. It is combinational.
- ID/EX update on every edge, priority order:
  1. flush (`wb_flush`||`ex_target_taken`): bubble.
  2. `id_stall`: bubble.
  3. otherwise: load the decoded instruction with `ex_valid`=1.
- Bubble definition: `ex_valid`=0, `ex_reg_we`=`ex_mem_read`=`ex_mem_write`=0, `ex_inst`=32'h0000_0013, `ex_rd`=0. Other fields are don't-care but deterministic (held).

## Timing
- Reset (async assert, sync release): all ID/EX outputs take bubble values, `ex_pc`=`RESET_PC`, `ex_imm`/data=0, `holding`=0, `id_stall`=0.
- Latency: the instruction present in ID at edge N appears on the `ex_*` outputs after edge N.
- A load-use stall lasts exactly 1 cycle: after the bubble, `ex_mem_read`=0, so `id_stall` drops.
- Flush and stall in the same cycle: flush wins, `id_stall`=0, a bubble is inserted, `holding` clears.
- Write-back to the same register as the read, in the same cycle: the bypass supplies the new value in the same cycle.
- Reset asserted mid-stall: `holding` and `id_stall` clear immediately.

## Configuration
- `ID_LOAD_USE_STALL_EN` defined: hazard detection as specified above.
- `ID_LOAD_USE_STALL_EN` undefined: `id_stall` is tied to 0, the hold register is removed, and loads never insert bubbles. This is for builds with MEM-to-EX load forwarding.

## Test plan
- Reset release, `id_inst_sel`=`INST_BIOS`, `bios_dout`=32'h0050_0093 (addi x1,x0,5), `id_pc`=32'h4000_0000 → next edge: `ex_valid`=1, `ex_rd`=1, `ex_imm`=5, `ex_reg_we`=1, `ex_pc`=32'h4000_0000.
- lw x2,0(x1), then add x3,x2,x2 → `id_stall`=1 for 1 cycle, one bubble (`ex_valid`=0), then the add issues with `ex_rs1`=`ex_rs2`=2. The held word is used even if `imem_dout` changes during the stall.
- `wb_we`=1, `wb_rd`=5, `wb_data`=32'hDEAD_BEEF while ID reads x5, `rf_rd1`=0 → `ex_rs1_data`=32'hDEAD_BEEF. With `wb_rd`=0, the bypass is ignored.
- Load-use stall coinciding with `ex_target_taken`=1 → `id_stall`=0, bubble, `holding`=0.
- `id_inst_sel`=2'b11 → `ex_inst`=32'h0000_0013, `ex_reg_we`=0. Immediates: beq offset −4 gives `ex_imm`=32'hFFFF_FFFC, and jal +2048 gives 32'h0000_0800.
- `ID_LOAD_USE_STALL_EN` undefined, same load-use sequence → no stall, back-to-back issue.
